// File: rtl/carry_resolver_nlane_pkg.sv
// Shared types and helpers for the N-lane carry resolver: FSM encoding,
// byte constants and the emit-byte mapping used by both emission states.
package carry_pkg;

    typedef enum logic [2:0] {IDLE, PROC, EMIT_PREV, EMIT_RUN, FLUSH, DONE} state_t;

    localparam logic [7:0] BYTE_FF   = 8'hFF;
    localparam int         CARRY_BIT = 8;

    // Held byte absorbs the carry; each deferred 0xFF wraps to 0x00 under a carry.
    function automatic logic [7:0] emit_byte(input logic is_prev, input logic [7:0] prev,
                                             input logic carry);
        if (is_prev) return prev + {7'd0, carry};
        return carry ? 8'h00 : BYTE_FF;
    endfunction

endpackage

// File: rtl/carry_resolver_nlane_lane_compactor.sv
// Packs the valid lanes of one input group into consecutive 9-bit slots
// (carry + byte), lowest lane in slot 0, and reports how many were valid.
module lane_compactor
    import carry_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int PB_WIDTH  = 16,
    parameter int CNT_WIDTH = 4
) (
    input  logic [NUM_LANES-1:0]          mask,
    input  logic [NUM_LANES*PB_WIDTH-1:0] words,
    output logic [NUM_LANES*9-1:0]        packed_words,
    output logic [CNT_WIDTH-1:0]          cnt
);

    // Bits above the carry carry no meaning here.
    logic words_unused;
    assign words_unused = ^words;

    // Walk lanes high to low, shifting each valid word in at slot 0, so the
    // lowest valid lane finishes in slot 0 without any variable indexing.
    always_comb begin
        packed_words = '0;
        cnt          = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                packed_words = (packed_words << 9) |
                               (NUM_LANES*9)'(words[i*PB_WIDTH +: CARRY_BIT+1]);
                cnt = cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/carry_resolver_nlane.sv
// Compacts lane groups of pre-bitstream words, resolves carries through a
// held byte plus a 0xFF run counter, and streams final bytes with a flush.
module carry_resolver_nlane
    import carry_pkg::*;
#(
    parameter int NUM_LANES      = 4,
    parameter int PB_WIDTH       = 16,
    parameter int RUN_WIDTH      = 8,
    parameter int LANE_IDX_WIDTH = 3
) (
    input  logic                          s4_clk,
    input  logic                          s4_reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_LANES-1:0]          in_lane_valid,
    input  logic [NUM_LANES*PB_WIDTH-1:0] in_pb,
    input  logic                          in_final,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_byte,
    output logic                          out_last,
    output logic                          out_done,
    output logic                          out_overflow
);

    localparam int CW = LANE_IDX_WIDTH + 1;
    localparam int BW = NUM_LANES * 9;

    state_t                 state;
    logic [BW-1:0]          word_buf, packed_words;
    logic [CW-1:0]          cnt, ptr, grp_cnt;
    logic                   final_pend, have_prev, emit_c, flushing;
    logic [7:0]             prev, next_prev;
    logic [RUN_WIDTH-1:0]   run;
    logic [8:0]             w;
    logic                   c, is_ff, hs, last_word, commit;
    state_t                 adv_state;

    lane_compactor #(.NUM_LANES(NUM_LANES), .PB_WIDTH(PB_WIDTH), .CNT_WIDTH(CW)) u_compact (
        .mask(in_lane_valid), .words(in_pb), .packed_words(packed_words), .cnt(grp_cnt)
    );

    // The buffer shifts down on each consumed word, so the current word is slot 0.
    assign w         = word_buf[8:0];
    assign c         = w[CARRY_BIT];
    assign is_ff     = !c && (w[7:0] == BYTE_FF);
    assign in_ready  = (state == IDLE);
    assign hs        = out_valid && out_ready;
    assign last_word = (ptr + CW'(1) == cnt);
    assign adv_state = last_word ? (final_pend ? FLUSH : IDLE) : PROC;
    assign commit    = hs && ((state == EMIT_PREV && run == '0) ||
                              (state == EMIT_RUN  && run == RUN_WIDTH'(1)));

    always_ff @(posedge s4_clk or posedge s4_reset) begin
        if (s4_reset) begin
            state        <= IDLE;
            word_buf     <= '0;
            cnt          <= '0;
            ptr          <= '0;
            final_pend   <= 1'b0;
            have_prev    <= 1'b0;
            prev         <= '0;
            next_prev    <= '0;
            run          <= '0;
            emit_c       <= 1'b0;
            flushing     <= 1'b0;
            out_valid    <= 1'b0;
            out_byte     <= '0;
            out_last     <= 1'b0;
            out_done     <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    word_buf   <= packed_words;
                    cnt        <= grp_cnt;
                    ptr        <= '0;
                    final_pend <= in_final;
                    if (grp_cnt != '0) state <= PROC;
                    else if (in_final) state <= FLUSH;
                end
                PROC: begin
                    if (!have_prev) begin
                        prev      <= w[7:0];
                        have_prev <= 1'b1;
                    end else if (is_ff) begin
                        if (&run) out_overflow <= 1'b1;
                        else      run <= run + RUN_WIDTH'(1);
                    end
                    if (!have_prev || is_ff) begin
                        word_buf <= word_buf >> 9;
                        ptr      <= ptr + CW'(1);
                        state    <= adv_state;
                    end else begin
                        state     <= EMIT_PREV;
                        emit_c    <= c;
                        next_prev <= w[7:0];
                        out_valid <= 1'b1;
                        out_byte  <= emit_byte(1'b1, prev, c);
                        out_last  <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (have_prev) begin
                        state     <= EMIT_PREV;
                        flushing  <= 1'b1;
                        emit_c    <= 1'b0;
                        out_valid <= 1'b1;
                        out_byte  <= prev;
                        out_last  <= (run == '0);
                    end else begin
                        state    <= DONE;
                        out_done <= 1'b1;
                    end
                end
                DONE: begin
                    out_done <= 1'b0;
                    state    <= IDLE;
                end
                EMIT_PREV: if (hs && run != '0) begin
                    state    <= EMIT_RUN;
                    out_byte <= emit_byte(1'b0, prev, emit_c);
                    out_last <= flushing && (run == RUN_WIDTH'(1));
                end
                EMIT_RUN: if (hs) begin
                    run      <= run - RUN_WIDTH'(1);
                    out_last <= flushing && (run == RUN_WIDTH'(2));
                end
                default: state <= IDLE;
            endcase

            // Last byte of a word's (or the flush's) emission has been taken.
            if (commit) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                run       <= '0;
                if (flushing) begin
                    flushing     <= 1'b0;
                    have_prev    <= 1'b0;
                    out_overflow <= 1'b0;
                    out_done     <= 1'b1;
                    state        <= DONE;
                end else begin
                    prev     <= next_prev;
                    word_buf <= word_buf >> 9;
                    ptr      <= ptr + CW'(1);
                    state    <= adv_state;
                end
            end
        end
    end

endmodule

// File: tb/tb_carry_resolver_nlane.sv
// Bench for carry_resolver_nlane: directed streams with literal byte lists
// plus randomized groups checked against a word-level carry model.
module tb_carry_resolver_nlane;

    localparam int NL = 4, PBW = 16, RW = 2, LIW = 3;
    localparam int RUN_MAX = (1 << RW) - 1;

    logic s4_clk = 1'b0, s4_reset = 1'b1;
    logic in_valid = 1'b0, in_final = 1'b0, out_ready = 1'b0;
    logic [NL-1:0]     in_lane_valid = '0;
    logic [NL*PBW-1:0] in_pb = '0;
    logic in_ready, out_valid, out_last, out_done, out_overflow;
    logic [7:0] out_byte;

    carry_resolver_nlane #(.NUM_LANES(NL), .PB_WIDTH(PBW), .RUN_WIDTH(RW), .LANE_IDX_WIDTH(LIW)) dut (
        .s4_clk(s4_clk), .s4_reset(s4_reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_lane_valid(in_lane_valid), .in_pb(in_pb), .in_final(in_final),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_last(out_last), .out_done(out_done), .out_overflow(out_overflow)
    );

    always #5 s4_clk = ~s4_clk;

    typedef struct { logic [7:0] val; logic last; logic ovf; } exp_t;
    typedef logic [8:0] exp6_t [6];

    int errors = 0, checks = 0;
    exp_t exp_q[$];
    exp_t cur;
    logic [8:0] got_q[$];
    int pending_done = 0;
    bit rnd_ready = 0;

    int m_prev, m_run;
    bit m_have, m_ovf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- word-level reference model ----------------
    function automatic void push_b(input logic [7:0] v, input logic last);
        exp_t e;
        e.val = v; e.last = last; e.ovf = m_ovf;
        exp_q.push_back(e);
    endfunction

    function automatic void model_word(input logic [8:0] wd);
        if (!m_have) begin
            m_prev = int'(wd[7:0]); m_have = 1;
        end else if (!wd[8] && wd[7:0] == 8'hFF) begin
            if (m_run == RUN_MAX) m_ovf = 1; else m_run++;
        end else begin
            push_b(8'(m_prev + int'(wd[8])), 1'b0);
            for (int k = 0; k < m_run; k++) push_b(wd[8] ? 8'h00 : 8'hFF, 1'b0);
            m_prev = int'(wd[7:0]); m_run = 0;
        end
    endfunction

    function automatic void model_flush();
        if (m_have) begin
            push_b(8'(m_prev), m_run == 0);
            for (int k = 1; k <= m_run; k++) push_b(8'hFF, k == m_run);
        end
        m_have = 0; m_run = 0; m_ovf = 0;
        pending_done++;
    endfunction

    function automatic void model_accept(input logic [NL-1:0] mask, input logic [NL*PBW-1:0] pb,
                                         input logic fin);
        for (int i = 0; i < NL; i++) if (mask[i]) model_word(pb[i*PBW +: 9]);
        if (fin) model_flush();
    endfunction

    function automatic void model_reset();
        m_prev = 0; m_run = 0; m_have = 0; m_ovf = 0;
        exp_q.delete();
        pending_done = 0;
    endfunction

    // ---------------- compare process ----------------
    logic stall_prev = 1'b0;
    logic [8:0] held;
    bit done_next = 0;

    always @(negedge s4_clk) begin
        if (s4_reset) begin
            stall_prev = 1'b0; done_next = 0;
        end else begin
            if (done_next) chk("done_after_last", out_done, 1);
            done_next = 0;
            if (out_done) begin
                chk("done_expected", pending_done != 0, 1);
                if (pending_done > 0) pending_done--;
            end
            if (stall_prev) chk("hold_stable", {out_valid, out_last, out_byte}, {1'b1, held});
            if (out_valid) chk("ready_while_valid", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_byte", exp_q.size(), 1);
                else begin
                    cur = exp_q.pop_front();
                    chk("byte", out_byte, cur.val);
                    chk("last", out_last, cur.last);
                    chk("overflow", out_overflow, cur.ovf);
                end
                got_q.push_back({out_last, out_byte});
                if (out_last) done_next = 1;
            end
            stall_prev = out_valid && !out_ready;
            held = {out_last, out_byte};
        end
    end

    always @(posedge s4_clk) if (rnd_ready) #1 out_ready = ($urandom % 4) != 0;

    // ---------------- driver helpers ----------------
    function automatic logic [NL*PBW-1:0] pk(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic align();
        @(posedge s4_clk); #1;
    endtask

    task automatic send_group(input logic [NL-1:0] mask, input logic [NL*PBW-1:0] pb, input logic fin);
        bit ok = 0;
        in_lane_valid = mask; in_pb = pb; in_final = fin; in_valid = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            @(negedge s4_clk);
            if (in_ready) begin model_accept(mask, pb, fin); ok = 1; break; end
        end
        chk("accept_timeout", ok, 1);
        @(posedge s4_clk); #1;
        in_valid = 1'b0; in_final = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge s4_clk);
            if (exp_q.size() == 0 && pending_done == 0 && in_ready) begin ok = 1; break; end
        end
        chk("drain_timeout", ok, 1);
        align();
    endtask

    task automatic wait_out_valid(input string name);
        bit ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge s4_clk);
            if (out_valid) begin ok = 1; break; end
        end
        chk(name, ok, 1);
    endtask

    task automatic check_got(input string name, input int n, input exp6_t e);
        chk({name, "_len"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++)
            chk($sformatf("%s[%0d]", name, i), got_q[i], e[i]);
    endtask

    function automatic logic [15:0] rword();
        logic [15:0] wd = 16'($urandom);
        if ($urandom % 3 == 0) wd[7:0] = 8'hFF;
        wd[8] = ($urandom % 4) == 0;
        return wd;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        bit ok;
        model_reset();
        repeat (3) @(posedge s4_clk);
        #1 s4_reset = 1'b0;
        @(negedge s4_clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_byte", out_byte, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_done", out_done, 0);
        chk("rst_overflow", out_overflow, 0);
        align();
        out_ready = 1'b1;

        got_q.delete();
        send_group(4'hF, pk(16'h012, 16'h034, 16'h056, 16'h078), 1'b0);
        send_group(4'h0, '0, 1'b1);
        drain();
        check_got("plain", 4, '{9'h012, 9'h034, 9'h056, 9'h178, 9'h0, 9'h0});

        got_q.delete();
        send_group(4'hF, pk(16'h0A0, 16'h0FF, 16'h0FF, 16'h105), 1'b0);
        send_group(4'h0, '0, 1'b1);
        drain();
        check_got("carry_run", 4, '{9'h0A1, 9'h000, 9'h000, 9'h105, 9'h0, 9'h0});

        got_q.delete();
        send_group(4'b0101, pk(16'h011, 16'h0EE, 16'h022, 16'h0CC), 1'b0);
        send_group(4'h0, '0, 1'b1);
        drain();
        check_got("sparse_mask", 2, '{9'h011, 9'h122, 9'h0, 9'h0, 9'h0, 9'h0});

        got_q.delete();
        send_group(4'b0111, pk(16'h033, 16'h0FF, 16'h0FF, 16'h0AB), 1'b0);
        send_group(4'h0, '0, 1'b1);
        drain();
        check_got("flush_run", 3, '{9'h033, 9'h0FF, 9'h1FF, 9'h0, 9'h0, 9'h0});

        // backpressure hold
        got_q.delete();
        out_ready = 1'b0;
        send_group(4'hF, pk(16'h044, 16'h055, 16'h066, 16'h077), 1'b0);
        wait_out_valid("stall_valid");
        for (int k = 0; k < 5; k++) begin
            @(negedge s4_clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_byte", {out_valid, out_byte}, 9'h144);
        end
        align();
        out_ready = 1'b1;
        send_group(4'h0, '0, 1'b1);
        drain();
        check_got("stall", 4, '{9'h044, 9'h055, 9'h066, 9'h177, 9'h0, 9'h0});

        // run counter saturation (RUN_WIDTH=2)
        got_q.delete();
        out_ready = 1'b0;
        send_group(4'hF, pk(16'h010, 16'h0FF, 16'h0FF, 16'h0FF), 1'b0);
        send_group(4'b0011, pk(16'h0FF, 16'h020, 16'h0, 16'h0), 1'b0);
        wait_out_valid("ovf_valid");
        chk("ovf_set", out_overflow, 1);
        align();
        out_ready = 1'b1;
        send_group(4'h0, '0, 1'b1);
        drain();
        check_got("overflow", 5, '{9'h010, 9'h0FF, 9'h0FF, 9'h0FF, 9'h120, 9'h0});
        chk("ovf_cleared", out_overflow, 0);

        // latency: held byte already present, new word emits in cycle t+2
        got_q.delete();
        send_group(4'b0001, pk(16'h011, 16'h0, 16'h0, 16'h0), 1'b0);
        drain();
        send_group(4'b0001, pk(16'h022, 16'h0, 16'h0, 16'h0), 1'b0);
        @(negedge s4_clk);
        chk("lat_t1_valid", out_valid, 0);
        @(negedge s4_clk);
        chk("lat_t2", {out_valid, out_byte}, 9'h111);
        align();
        send_group(4'h0, '0, 1'b1);
        drain();
        check_got("latency", 2, '{9'h011, 9'h122, 9'h0, 9'h0, 9'h0, 9'h0});

        // reset in the middle of a run emission
        got_q.delete();
        send_group(4'hF, pk(16'h010, 16'h0FF, 16'h0FF, 16'h020), 1'b0);
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge s4_clk);
            if (got_q.size() >= 1) begin ok = 1; break; end
        end
        chk("mid_first_byte", ok, 1);
        #1 out_ready = 1'b0;
        repeat (2) @(posedge s4_clk);
        #2 s4_reset = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_last", out_last, 0);
        model_reset();
        repeat (2) @(posedge s4_clk);
        #1 s4_reset = 1'b0;
        @(negedge s4_clk);
        chk("post_rst_ready", in_ready, 1);
        align();
        out_ready = 1'b1;
        got_q.delete();
        send_group(4'b0011, pk(16'h150, 16'h060, 16'h0, 16'h0), 1'b1);
        drain();
        check_got("after_reset", 2, '{9'h050, 9'h160, 9'h0, 9'h0, 9'h0, 9'h0});

        // randomized groups against the model
        rnd_ready = 1;
        for (int g = 0; g < 300; g++)
            send_group(NL'($urandom), pk(rword(), rword(), rword(), rword()), ($urandom % 8) == 0);
        send_group(4'h0, '0, 1'b1);
        drain();
        rnd_ready = 0;

        chk("exp_q_empty", exp_q.size(), 0);
        chk("pending_done_zero", pending_done, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
